vga_timing_gen: RTL and testbench

Parametrised video timing generator that produces sync, blanking and pixel coordinates for any raster mode. Horizontal and vertical timings and sync polarities are set by parameters. Outputs pass through a configurable delay so they line up with a downstream pixel pipeline. The block also provides a look-ahead fetch strobe for frame-buffer reads and frame, line and vblank event pulses. It sits between the pixel-clock domain and the DAC/monitor port, feeding the frame-buffer read controller.

---
 rtl/vga_timing_gen_pkg.sv | 47 ++++
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared video timing definitions: common mode constants, output flag bundle
// and small helpers for deriving raster totals and counter widths.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        h_pol;
        logic        v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                              v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                                              h_pol: 1'b0, v_pol: 1'b0};
    localparam vga_mode_t MODE_800X600_60 = '{h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
                                              v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23,
                                              h_pol: 1'b1, v_pol: 1'b1};
    localparam vga_mode_t MODE_1280X720_60 = '{h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
                                               v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20,
                                               h_pol: 1'b1, v_pol: 1'b1};

    // Per-pixel flags carried down the output pipeline alongside the coordinates
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic frame_start;
        logic line_start;
        logic vblank_start;
    } vga_flags_t;

    function automatic int unsigned timing_total(input int unsigned active, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned coord_width(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bus of the timing generator plus its run-enable input.
interface vga_timing_gen_if #(parameter int unsigned CW = 11);
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          blank_n;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          fetch;
    logic          frame_start;
    logic          line_start;
    logic          vblank_start;

    modport master (input en, output hsync, vsync, active, blank_n, hcnt, vcnt,
                    fetch, frame_start, line_start, vblank_start);
    modport slave  (output en, input hsync, vsync, active, blank_n, hcnt, vcnt,
                    fetch, frame_start, line_start, vblank_start);
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Generic width x depth register shift with per-bit reset value and a
// single-bit tap at a selectable stage.
module vga_delay_line #(
    parameter int unsigned     WIDTH     = 1,
    parameter int unsigned     DEPTH     = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int unsigned     TAP_STAGE = 0,
    parameter int unsigned     TAP_BIT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             tap
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];
    assign tap  = stage_q[TAP_STAGE][TAP_BIT];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/active/event
// decode, and a delay pipeline with an early fetch tap on the active flag.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned CW         = 11,
    parameter int unsigned DELAY      = 2,
    parameter int unsigned FETCH_LEAD = 2
) (
    input  logic             CLK25,
    input  logic             reset,
    vga_timing_gen_if.master vif
);

    localparam int unsigned H_TOTAL    = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL    = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned FLAGS_W    = $bits(vga_flags_t);
    localparam int unsigned BW         = FLAGS_W + 2 * CW;
    localparam int unsigned ACTIVE_BIT = 2 * CW + 3;  // position of flags.active in {flags, h, v}

    localparam vga_flags_t IDLE_FLAGS = '{hsync: ~H_POL, vsync: ~V_POL, default: 1'b0};
    localparam logic [BW-1:0] RST_VAL = {IDLE_FLAGS, {(2*CW){1'b0}}};

    logic [CW-1:0] h_q, v_q;
    logic [31:0]   h_w, v_w;
    vga_flags_t    flags_c;
    logic [CW-1:0] hcoord_c, vcoord_c;
    logic [BW-1:0] bundle_c, bundle_q;
    vga_flags_t    out_flags;
    logic          fetch_q;

    // Raster counters; disabled means parked at the origin
    always_ff @(posedge CLK25 or negedge reset) begin
        if (!reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (!vif.en) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == CW'(H_TOTAL - 1)) begin
            h_q <= '0;
            v_q <= (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
        end else begin
            h_q <= h_q + CW'(1);
        end
    end

    assign h_w = 32'(h_q);
    assign v_w = 32'(v_q);

    always_comb begin
        flags_c  = IDLE_FLAGS;
        hcoord_c = '0;
        vcoord_c = '0;
        if (vif.en) begin
            flags_c.active       = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
            flags_c.hsync        = ((h_w >= H_ACTIVE + H_FP) && (h_w < H_ACTIVE + H_FP + H_SYNC))
                                   ? H_POL : ~H_POL;
            flags_c.vsync        = ((v_w >= V_ACTIVE + V_FP) && (v_w < V_ACTIVE + V_FP + V_SYNC))
                                   ? V_POL : ~V_POL;
            flags_c.line_start   = (h_w == 0);
            flags_c.frame_start  = (h_w == 0) && (v_w == 0);
            flags_c.vblank_start = (h_w == 0) && (v_w == V_ACTIVE);
            hcoord_c             = h_q;
            vcoord_c             = v_q;
        end
    end

    assign bundle_c = {flags_c, hcoord_c, vcoord_c};

    vga_delay_line #(
        .WIDTH    (BW),
        .DEPTH    (DELAY + 1),
        .RST_VAL  (RST_VAL),
        .TAP_STAGE(DELAY - FETCH_LEAD),
        .TAP_BIT  (ACTIVE_BIT)
    ) u_pipe (
        .clk  (CLK25),
        .rst_n(reset),
        .din  (bundle_c),
        .dout (bundle_q),
        .tap  (fetch_q)
    );

    assign out_flags        = vga_flags_t'(bundle_q[BW-1 -: FLAGS_W]);
    assign vif.hsync        = out_flags.hsync;
    assign vif.vsync        = out_flags.vsync;
    assign vif.active       = out_flags.active;
    assign vif.blank_n      = out_flags.active;
    assign vif.frame_start  = out_flags.frame_start;
    assign vif.line_start   = out_flags.line_start;
    assign vif.vblank_start = out_flags.vblank_start;
    assign vif.hcnt         = bundle_q[2*CW-1 -: CW];
    assign vif.vcnt         = bundle_q[CW-1:0];
    assign vif.fetch        = fetch_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three generator instances (small active-low, small
// active-high zero-delay, default 640x480) checked against a raster model.
module tb_vga_timing_gen;

    localparam int NI = 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        act;
        logic [10:0] h;
        logic [10:0] v;
        logic        fs;
        logic        ls;
        logic        vbs;
    } bnd_t;

    typedef struct {
        int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp, dly, fl;
        logic        hpol, vpol;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    int unsigned mh [NI];
    int unsigned mv [NI];
    bnd_t        sbq [NI][$];

    bnd_t obs [NI];
    logic obs_fetch [NI];
    logic obs_blank [NI];

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(6))  ia ();
    vga_timing_gen_if #(.CW(6))  ib ();
    vga_timing_gen_if #(.CW(11)) ic ();

    assign ia.en = en;
    assign ib.en = en;
    assign ic.en = en;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .CW(6), .DELAY(2),
                     .FETCH_LEAD(2))
        u_a (.CLK25(clk), .reset(rst_n), .vif(ia));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .CW(6), .DELAY(0),
                     .FETCH_LEAD(0))
        u_b (.CLK25(clk), .reset(rst_n), .vif(ib));

    vga_timing_gen #(.CW(11), .FETCH_LEAD(1))
        u_c (.CLK25(clk), .reset(rst_n), .vif(ic));

    assign obs[0] = {ia.hsync, ia.vsync, ia.active, 11'(ia.hcnt), 11'(ia.vcnt),
                     ia.frame_start, ia.line_start, ia.vblank_start};
    assign obs[1] = {ib.hsync, ib.vsync, ib.active, 11'(ib.hcnt), 11'(ib.vcnt),
                     ib.frame_start, ib.line_start, ib.vblank_start};
    assign obs[2] = {ic.hsync, ic.vsync, ic.active, ic.hcnt, ic.vcnt,
                     ic.frame_start, ic.line_start, ic.vblank_start};
    assign obs_fetch[0] = ia.fetch;
    assign obs_fetch[1] = ib.fetch;
    assign obs_fetch[2] = ic.fetch;
    assign obs_blank[0] = ia.blank_n;
    assign obs_blank[1] = ib.blank_n;
    assign obs_blank[2] = ic.blank_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic cfg_t cfg(input int i);
        cfg_t c;
        if (i == 2)
            c = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33,
                  dly: 2, fl: 1, hpol: 1'b0, vpol: 1'b0};
        else
            c = '{ha: 8, hfp: 2, hsw: 3, hbp: 2, va: 4, vfp: 1, vsw: 2, vbp: 1,
                  dly: (i == 0) ? 2 : 0, fl: (i == 0) ? 2 : 0,
                  hpol: (i == 1) ? 1'b1 : 1'b0, vpol: (i == 1) ? 1'b1 : 1'b0};
        return c;
    endfunction

    // Expected output bundle for raster position (h,v) entering the pipeline
    function automatic bnd_t model_bundle(input int i, input int unsigned h, input int unsigned v,
                                          input logic run);
        cfg_t c = cfg(i);
        bnd_t b = '0;
        b.hs = ~c.hpol;
        b.vs = ~c.vpol;
        if (run) begin
            b.act = (h < c.ha) && (v < c.va);
            if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) b.hs = c.hpol;
            if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) b.vs = c.vpol;
            b.h   = 11'(h);
            b.v   = 11'(v);
            b.fs  = (h == 0) && (v == 0);
            b.ls  = (h == 0);
            b.vbs = (h == 0) && (v == c.va);
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mh[i] = 0;
            mv[i] = 0;
            sbq[i].delete();
            for (int unsigned k = 0; k < cfg(i).dly; k++) sbq[i].push_back(model_bundle(i, 0, 0, 1'b0));
        end
    endtask

    // One pixel clock: drive en, push expected bundles at the edge, compare #1 later
    task automatic tick(input logic en_val);
        bnd_t exp_b;
        logic exp_f;
        en = en_val;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            cfg_t c = cfg(i);
            int unsigned ht = c.ha + c.hfp + c.hsw + c.hbp;
            int unsigned vt = c.va + c.vfp + c.vsw + c.vbp;
            sbq[i].push_back(model_bundle(i, mh[i], mv[i], en));
            if (!en) begin
                mh[i] = 0;
                mv[i] = 0;
            end else if (mh[i] == ht - 1) begin
                mh[i] = 0;
                mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
            end else begin
                mh[i] = mh[i] + 1;
            end
        end
        cyc++;
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_f = sbq[i][cfg(i).fl].act;
            exp_b = sbq[i].pop_front();
            check($sformatf("bundle%0d", i), 32'(obs[i]), 32'(exp_b));
            check($sformatf("fetch%0d", i), 32'(obs_fetch[i]), 32'(exp_f));
            check($sformatf("blank_n%0d", i), 32'(obs_blank[i]), 32'(exp_b.act));
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_bundle%0d", tag, i), 32'(obs[i]), 32'(model_bundle(i, 0, 0, 1'b0)));
            check($sformatf("%s_fetch%0d", tag, i), 32'(obs_fetch[i]), 32'd0);
            check($sformatf("%s_blank%0d", tag, i), 32'(obs_blank[i]), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        int start;
        int last_ls;
        int hs_run;
        logic prev_hs;

        repeat (2) @(negedge clk);
        check_reset_values("rst_init");
        check("b_rst_hsync_lvl", 32'(ib.hsync), 32'd0);
        check("a_rst_hsync_lvl", 32'(ia.hsync), 32'd1);

        // Release with en already high; small zero-delay instance shows origin first
        model_reset();
        rst_n = 1'b1;
        tick(1'b1);
        check("b_fs_latency", 32'({ib.frame_start, ib.hcnt, ib.vcnt}), 32'({1'b1, 6'd0, 6'd0}));
        tick(1'b1);
        tick(1'b1);
        check("a_fs_latency", 32'({ia.frame_start, ia.active, ia.hcnt, ia.vcnt}),
              32'({1'b1, 1'b1, 6'd0, 6'd0}));
        start = cyc;

        cnt = int'(ia.active);
        for (int n = 0; n < 14; n++) begin
            tick(1'b1);
            cnt += int'(ia.active);
        end
        check("a_active_per_line", 32'(cnt), 32'd8);

        for (int n = 0; n < 300; n++) begin
            tick(1'b1);
            if (ia.vblank_start) check("a_vblank_pos", 32'({ia.hcnt, ia.vcnt}), 32'({6'd0, 6'd4}));
            if (ia.frame_start) break;
        end
        check("a_frame_period", 32'(cyc - start), 32'd120);

        // Default mode: hsync window and line period
        last_ls = -1;
        hs_run  = 0;
        prev_hs = ic.hsync;
        for (int n = 0; n < 1700; n++) begin
            tick(1'b1);
            if (ic.line_start) begin
                if (last_ls >= 0) check("c_line_period", 32'(cyc - last_ls), 32'd800);
                last_ls = cyc;
            end
            if (prev_hs && !ic.hsync) begin
                check("c_hsync_start", 32'(ic.hcnt), 32'd656);
                hs_run = 1;
            end else if (!ic.hsync) begin
                hs_run++;
            end else if (!prev_hs && ic.hsync) begin
                check("c_hsync_width", 32'(hs_run), 32'd96);
            end
            prev_hs = ic.hsync;
        end

        // Drop en when the small raster sits at (5,2)
        for (int n = 0; n < 200 && !(mh[0] == 5 && mv[0] == 2); n++) tick(1'b1);
        check("a_reach_5_2", 32'({mh[0][15:0], mv[0][15:0]}), 32'({16'd5, 16'd2}));
        repeat (3) tick(1'b0);
        check("a_idle_after_drop", 32'(obs[0]), 32'(model_bundle(0, 0, 0, 1'b0)));
        repeat (2) tick(1'b0);
        repeat (3) tick(1'b1);
        check("a_restart_fs", 32'({ia.frame_start, ia.hcnt, ia.vcnt}), 32'({1'b1, 6'd0, 6'd0}));
        repeat (20) tick(1'b1);

        // Asynchronous reset in the middle of a line
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (3) tick(1'b1);
        check("a_fs_after_reset", 32'({ia.frame_start, ia.hcnt, ia.vcnt}), 32'({1'b1, 6'd0, 6'd0}));
        repeat (130) tick(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
